// File: rtl/apb_global_pkg.sv
// Shared APB widths, state/response encodings and protocol limits.
package apb_global_pkg;

  localparam int unsigned ADDRESS_WIDTH   = 32;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned STRB_WIDTH      = DATA_WIDTH / 8;
  localparam int unsigned MAX_WAIT_STATES = 15;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_fsm_state_e;

  typedef enum logic {
    SLV_OKAY  = 1'b0,
    SLV_ERROR = 1'b1
  } slave_error_e;

  typedef enum logic {
    TX_READ  = 1'b0,
    TX_WRITE = 1'b1
  } tx_type_e;

  typedef enum logic [2:0] {
    PROT_NORMAL_SECURE_DATA       = 3'b000,
    PROT_PRIV_SECURE_DATA         = 3'b001,
    PROT_NORMAL_NONSECURE_DATA    = 3'b010,
    PROT_PRIV_NONSECURE_DATA      = 3'b011,
    PROT_NORMAL_SECURE_INSTR      = 3'b100,
    PROT_PRIV_SECURE_INSTR        = 3'b101,
    PROT_NORMAL_NONSECURE_INSTR   = 3'b110,
    PROT_PRIV_NONSECURE_INSTR     = 3'b111
  } protection_type_e;

endpackage

// File: rtl/apb_slave_mem_pkg.sv
// Local constants and helpers for the APB memory completer.
package apb_slave_mem_pkg;
  import apb_global_pkg::*;

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT_STATES + 1);

  function automatic int unsigned mem_idx_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/apb_slave_mem_if.sv
// APB4 bus bundle between a requester (master) and completer (slave).
interface apb_slave_mem_if;
  import apb_global_pkg::*;

  logic                     psel;
  logic                     penable;
  logic                     pwrite;
  logic [ADDRESS_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0]    pwdata;
  logic [STRB_WIDTH-1:0]    pstrb;
  logic [2:0]               pprot;
  logic                     pready;
  logic [DATA_WIDTH-1:0]    prdata;
  logic                     pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_slave_mem_array.sv
// Word storage with byte-strobe synchronous write, combinational read, synchronous clear.
module apb_slave_mem_array #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 64,
  parameter int unsigned IDX_W      = 6
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_we,
  input  logic [IDX_W-1:0]        i_widx,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_strb,
  input  logic [IDX_W-1:0]        i_ridx,
  output logic [DATA_WIDTH-1:0]   o_rdata_c
);

  localparam int unsigned SW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= '0;
    end else if (i_we) begin
      for (int b = 0; b < SW; b++) begin
        if (i_strb[b]) r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
      end
    end
  end

  assign o_rdata_c = r_mem[i_ridx];

endmodule

// File: rtl/apb_slave_mem.sv
// APB4 completer: word memory, programmable wait states, range/alignment errors.
// Define APB_SLAVE_MEM_PROT_CHECK_EN to reject nonsecure writes to the upper half.
module apb_slave_mem #(
  parameter int unsigned               ADDRESS_WIDTH = apb_global_pkg::ADDRESS_WIDTH,
  parameter int unsigned               DATA_WIDTH    = apb_global_pkg::DATA_WIDTH,
  parameter int unsigned               MEM_DEPTH     = 64,
  parameter logic [ADDRESS_WIDTH-1:0]  BASE_ADDR     = '0
) (
  input  logic                           pclk,
  input  logic                           preset_n,
  input  logic [apb_slave_mem_pkg::WAIT_W-1:0] cfg_wait_states,
  apb_slave_mem_if.slave                 bus
);
  import apb_global_pkg::*;
  import apb_slave_mem_pkg::*;

  localparam int unsigned SW    = DATA_WIDTH / 8;
  localparam int unsigned IDX_W = mem_idx_width(MEM_DEPTH);
  localparam logic [ADDRESS_WIDTH-1:0] SPAN = ADDRESS_WIDTH'(MEM_DEPTH * SW);

  apb_fsm_state_e          r_state, w_state_nxt, w_phase;
  logic                    r_pready, w_pready_nxt;
  logic [DATA_WIDTH-1:0]   r_prdata, w_prdata_nxt;
  logic                    r_pslverr, w_pslverr_nxt;
  logic [WAIT_W-1:0]       r_wait, w_wait_nxt;
  tx_type_e                r_tx, w_tx_nxt;
  slave_error_e            r_err, w_err_nxt;
  logic [IDX_W-1:0]        r_idx, w_idx_nxt;
  logic [DATA_WIDTH-1:0]   r_wdata, w_wdata_nxt;
  logic [SW-1:0]           r_strb, w_strb_nxt;

  logic [ADDRESS_WIDTH-1:0] w_offset;
  logic [IDX_W-1:0]         w_addr_idx;
  slave_error_e             w_addr_err;
  logic                     w_we;
  logic [IDX_W-1:0]         w_rd_idx;
  logic [DATA_WIDTH-1:0]    w_rd_word;

  // Address decode; range is checked before the offset is trusted as an index.
  always_comb begin
    w_offset   = bus.paddr - BASE_ADDR;
    w_addr_idx = IDX_W'(w_offset / ADDRESS_WIDTH'(SW));
    w_addr_err = SLV_OKAY;
    if ((bus.paddr < BASE_ADDR) || (w_offset >= SPAN) ||
        ((bus.paddr % ADDRESS_WIDTH'(SW)) != '0))
      w_addr_err = SLV_ERROR;
`ifdef APB_SLAVE_MEM_PROT_CHECK_EN
    if (bus.pwrite && bus.pprot[1] && (w_addr_idx >= IDX_W'(MEM_DEPTH / 2)))
      w_addr_err = SLV_ERROR;
`endif
  end

  // A SETUP is recognised from the bus itself, so it can follow a completion or pre-empt an ACCESS.
  always_comb begin
    w_phase       = IDLE;
    w_state_nxt   = IDLE;
    w_pready_nxt  = 1'b0;
    w_prdata_nxt  = '0;
    w_pslverr_nxt = 1'b0;
    w_wait_nxt    = r_wait;
    w_tx_nxt      = r_tx;
    w_err_nxt     = r_err;
    w_idx_nxt     = r_idx;
    w_wdata_nxt   = r_wdata;
    w_strb_nxt    = r_strb;
    w_we          = 1'b0;

    if (bus.psel && !bus.penable)            w_phase = SETUP;
    else if ((r_state == ACCESS) && bus.psel) w_phase = ACCESS;

    w_rd_idx = (w_phase == SETUP) ? w_addr_idx : r_idx;

    case (w_phase)
      SETUP: begin
        w_state_nxt = ACCESS;
        w_tx_nxt    = tx_type_e'(bus.pwrite);
        w_err_nxt   = w_addr_err;
        w_idx_nxt   = w_addr_idx;
        w_wdata_nxt = bus.pwdata;
        w_strb_nxt  = bus.pstrb;
        if (cfg_wait_states == '0) begin
          w_pready_nxt  = 1'b1;
          w_pslverr_nxt = (w_addr_err == SLV_ERROR);
          if (!bus.pwrite && (w_addr_err == SLV_OKAY)) w_prdata_nxt = w_rd_word;
        end else begin
          w_wait_nxt = cfg_wait_states - WAIT_W'(1);
        end
      end
      ACCESS: begin
        w_state_nxt = ACCESS;
        if (r_pready) begin
          w_state_nxt = IDLE;
          w_we        = (r_tx == TX_WRITE) && (r_err == SLV_OKAY);
        end else if (r_wait == '0) begin
          w_pready_nxt  = 1'b1;
          w_pslverr_nxt = (r_err == SLV_ERROR);
          if ((r_tx == TX_READ) && (r_err == SLV_OKAY)) w_prdata_nxt = w_rd_word;
        end else begin
          w_wait_nxt = r_wait - WAIT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      r_state   <= IDLE;
      r_pready  <= 1'b0;
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
      r_wait    <= '0;
      r_tx      <= TX_READ;
      r_err     <= SLV_OKAY;
      r_idx     <= '0;
      r_wdata   <= '0;
      r_strb    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pready  <= w_pready_nxt;
      r_prdata  <= w_prdata_nxt;
      r_pslverr <= w_pslverr_nxt;
      r_wait    <= w_wait_nxt;
      r_tx      <= w_tx_nxt;
      r_err     <= w_err_nxt;
      r_idx     <= w_idx_nxt;
      r_wdata   <= w_wdata_nxt;
      r_strb    <= w_strb_nxt;
    end
  end

  apb_slave_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk       (pclk),
    .rst_n     (preset_n),
    .i_we      (w_we),
    .i_widx    (r_idx),
    .i_wdata   (r_wdata),
    .i_strb    (r_strb),
    .i_ridx    (w_rd_idx),
    .o_rdata_c (w_rd_word)
  );

  assign bus.pready  = r_pready;
  assign bus.prdata  = r_prdata;
  assign bus.pslverr = r_pslverr;

endmodule

// File: tb/tb_apb_slave_mem.sv
// Self-checking bench for apb_slave_mem against a word-array reference model.
module tb_apb_slave_mem;
  import apb_global_pkg::*;

  localparam logic [31:0] BASE  = 32'h0;
  localparam int unsigned DEPTH = 64;

  logic       pclk = 1'b0;
  logic       preset_n;
  logic [3:0] cfg;

  apb_slave_mem_if bus ();

  apb_slave_mem #(
    .ADDRESS_WIDTH (32),
    .DATA_WIDTH    (32),
    .MEM_DEPTH     (DEPTH),
    .BASE_ADDR     (BASE)
  ) dut (
    .pclk            (pclk),
    .preset_n        (preset_n),
    .cfg_wait_states (cfg),
    .bus             (bus.slave)
  );

  always #5 pclk = ~pclk;

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] mem_m [DEPTH];

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  // Reference: error rules and byte-lane commit computed straight from the address map.
  task automatic model(input logic w, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input logic [2:0] p,
                       output logic [31:0] erd, output logic eerr);
    int unsigned idx;
    eerr = (a < BASE) || (a >= BASE + DEPTH * 4) || ((a % 4) != 0);
    idx  = (a - BASE) / 4;
`ifdef APB_SLAVE_MEM_PROT_CHECK_EN
    if (!eerr && w && p[1] && (idx >= DEPTH / 2)) eerr = 1'b1;
`else
    if (p === 3'bxxx) eerr = 1'bx;
`endif
    erd = '0;
    if (!eerr) begin
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) mem_m[idx][8*b +: 8] = d[8*b +: 8];
        end
      end else begin
        erd = mem_m[idx];
      end
    end
  endtask

  // Drives one SETUP + ACCESS; returns in the completion cycle (lat=99 if it never completes).
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [2:0] p, input logic [3:0] n,
                      output logic [31:0] rd, output logic er, output int lat);
    tick();
    cfg = n; bus.psel = 1'b1; bus.penable = 1'b0;
    bus.pwrite = w; bus.paddr = a; bus.pwdata = d; bus.pstrb = s; bus.pprot = p;
    tick();
    bus.penable = 1'b1;
    lat = 99; rd = 'x; er = 1'bx;
    for (int k = 0; k < 40; k++) begin
      if (bus.pready === 1'b1) begin
        lat = k; rd = bus.prdata; er = bus.pslverr;
        break;
      end
      tick();
    end
  endtask

  task automatic idle();
    tick();
    bus.psel = 1'b0; bus.penable = 1'b0;
  endtask

  task automatic test_reset();
    preset_n = 1'b0; bus.psel = 1'b0; bus.penable = 1'b0; cfg = '0;
    bus.pwrite = 1'b0; bus.paddr = '0; bus.pwdata = '0; bus.pstrb = '0; bus.pprot = '0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    repeat (3) tick();
    n_total++; if (bus.pready  !== 1'b0)  $display("FAIL rst_pready got %b want 0", bus.pready);  else n_pass++;
    n_total++; if (bus.prdata  !== 32'h0) $display("FAIL rst_prdata got %h want 0", bus.prdata);  else n_pass++;
    n_total++; if (bus.pslverr !== 1'b0)  $display("FAIL rst_pslverr got %b want 0", bus.pslverr); else n_pass++;
    preset_n = 1'b1;
    idle();
  endtask

  task automatic test_write_read();
    logic [31:0] rd, erd; logic er, eer; int lat;
    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, 4'd0, rd, er, lat);
    model(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, erd, eer);
    n_total++; if (lat !== 0)   $display("FAIL wr_lat got %0d want 0", lat);     else n_pass++;
    n_total++; if (er  !== eer) $display("FAIL wr_err got %b want %b", er, eer); else n_pass++;
    n_total++; if (rd  !== erd) $display("FAIL wr_rdata got %h want %h", rd, erd); else n_pass++;
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, lat);
    model(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, erd, eer);
    n_total++; if (lat !== 0)            $display("FAIL rd_lat got %0d want 0", lat);          else n_pass++;
    n_total++; if (er  !== 1'b0)         $display("FAIL rd_err got %b want 0", er);            else n_pass++;
    n_total++; if (rd  !== 32'hDEADBEEF) $display("FAIL rd_data got %h want deadbeef", rd);    else n_pass++;
    idle();
  endtask

  task automatic test_strobes();
    logic [31:0] rd, erd; logic er, eer; int lat;
    xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 3'b000, 4'd0, rd, er, lat);
    model(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 3'b000, erd, eer);
    xfer(1'b1, 32'h20, 32'h12345678, 4'b0101, 3'b000, 4'd0, rd, er, lat);
    model(1'b1, 32'h20, 32'h12345678, 4'b0101, 3'b000, erd, eer);
    xfer(1'b1, 32'h20, 32'h00000000, 4'b0000, 3'b000, 4'd1, rd, er, lat);
    model(1'b1, 32'h20, 32'h00000000, 4'b0000, 3'b000, erd, eer);
    n_total++; if (er !== 1'b0) $display("FAIL strb0_err got %b want 0", er); else n_pass++;
    xfer(1'b0, 32'h20, 32'h0, 4'hF, 3'b000, 4'd0, rd, er, lat);
    model(1'b0, 32'h20, 32'h0, 4'hF, 3'b000, erd, eer);
    n_total++; if (rd !== 32'hFF34FF78) $display("FAIL strb_data got %h want ff34ff78", rd); else n_pass++;
    n_total++; if (rd !== erd)          $display("FAIL strb_model got %h want %h", rd, erd); else n_pass++;
    idle();
  endtask

  task automatic test_wait_states();
    logic [31:0] rd, erd; logic er, eer; int lat;
    xfer(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 4'd3, rd, er, lat);
    model(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, erd, eer);
    n_total++; if (lat !== 3)   $display("FAIL ws3_lat got %0d want 3", lat);      else n_pass++;
    n_total++; if (rd  !== erd) $display("FAIL ws3_rdata got %h want %h", rd, erd); else n_pass++;
    // wait count is taken at SETUP; changing it mid-ACCESS must not matter
    tick();
    cfg = 4'd2; bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = 32'h10;
    tick();
    bus.penable = 1'b1; cfg = 4'd0;
    n_total++; if (bus.pready !== 1'b0) $display("FAIL cfg_k0 got %b want 0", bus.pready); else n_pass++;
    tick();
    n_total++; if (bus.pready !== 1'b0) $display("FAIL cfg_k1 got %b want 0", bus.pready); else n_pass++;
    tick();
    n_total++; if (bus.pready !== 1'b1) $display("FAIL cfg_k2 got %b want 1", bus.pready); else n_pass++;
    n_total++; if (bus.prdata !== mem_m[4]) $display("FAIL cfg_data got %h want %h", bus.prdata, mem_m[4]); else n_pass++;
    idle();
  endtask

  task automatic test_errors();
    logic [31:0] rd, erd; logic er, eer; int lat;
    xfer(1'b1, 32'h100, 32'hA5A5A5A5, 4'hF, 3'b000, 4'd1, rd, er, lat);
    model(1'b1, 32'h100, 32'hA5A5A5A5, 4'hF, 3'b000, erd, eer);
    n_total++; if (lat !== 1)    $display("FAIL err_oob_lat got %0d want 1", lat);  else n_pass++;
    n_total++; if (er  !== 1'b1) $display("FAIL err_oob got %b want 1", er);        else n_pass++;
    n_total++; if (rd  !== 32'h0) $display("FAIL err_oob_rdata got %h want 0", rd); else n_pass++;
    xfer(1'b1, 32'h13, 32'h11111111, 4'hF, 3'b000, 4'd0, rd, er, lat);
    model(1'b1, 32'h13, 32'h11111111, 4'hF, 3'b000, erd, eer);
    n_total++; if (er !== 1'b1) $display("FAIL err_align got %b want 1", er); else n_pass++;
    xfer(1'b1, 32'hFC, 32'h0BADF00D, 4'hF, 3'b000, 4'd0, rd, er, lat);
    model(1'b1, 32'hFC, 32'h0BADF00D, 4'hF, 3'b000, erd, eer);
    n_total++; if (er !== 1'b0) $display("FAIL err_last_word got %b want 0", er); else n_pass++;
    xfer(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, lat);
    model(1'b0, 32'h0, 32'h0, 4'h0, 3'b000, erd, eer);
    n_total++; if (rd !== erd) $display("FAIL err_word0 got %h want %h", rd, erd); else n_pass++;
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, lat);
    n_total++; if (rd !== 32'hDEADBEEF) $display("FAIL err_word4 got %h want deadbeef", rd); else n_pass++;
    idle();
  endtask

  task automatic test_abort();
    logic [31:0] rd, erd; logic er, eer; int lat;
    tick();
    cfg = 4'd4; bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 32'h40; bus.pwdata = 32'hAAAA5555; bus.pstrb = 4'hF; bus.pprot = 3'b000;
    tick();
    bus.penable = 1'b1;
    tick();
    bus.psel = 1'b0; bus.penable = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_total++; if (bus.pready !== 1'b0) $display("FAIL abort_pready c%0d got %b want 0", i, bus.pready); else n_pass++;
    end
    // penable without a preceding SETUP is ignored
    bus.psel = 1'b1; bus.penable = 1'b1;
    repeat (3) tick();
    n_total++; if (bus.pready !== 1'b0) $display("FAIL idle_penable got %b want 0", bus.pready); else n_pass++;
    bus.psel = 1'b0; bus.penable = 1'b0;
    xfer(1'b0, 32'h40, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, lat);
    model(1'b0, 32'h40, 32'h0, 4'h0, 3'b000, erd, eer);
    n_total++; if (rd !== erd) $display("FAIL abort_mem got %h want %h", rd, erd); else n_pass++;
    n_total++; if (lat !== 0)  $display("FAIL abort_next_lat got %0d want 0", lat); else n_pass++;
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd, erd; logic er, eer; int lat;
    xfer(1'b1, 32'h44, 32'h01020304, 4'hF, 3'b000, 4'd0, rd, er, lat);
    model(1'b1, 32'h44, 32'h01020304, 4'hF, 3'b000, erd, eer);
    xfer(1'b1, 32'h48, 32'h05060708, 4'hF, 3'b000, 4'd2, rd, er, lat);
    model(1'b1, 32'h48, 32'h05060708, 4'hF, 3'b000, erd, eer);
    n_total++; if (lat !== 2) $display("FAIL b2b_lat got %0d want 2", lat); else n_pass++;
    xfer(1'b0, 32'h44, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, lat);
    n_total++; if (rd !== 32'h01020304) $display("FAIL b2b_w1 got %h want 01020304", rd); else n_pass++;
    xfer(1'b0, 32'h48, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, lat);
    n_total++; if (rd !== 32'h05060708) $display("FAIL b2b_w2 got %h want 05060708", rd); else n_pass++;
    idle();
  endtask

  task automatic test_prot();
    logic [31:0] rd, erd; logic er, eer; int lat;
    xfer(1'b1, 32'h80, 32'h77777777, 4'hF, 3'b010, 4'd0, rd, er, lat);
    model(1'b1, 32'h80, 32'h77777777, 4'hF, 3'b010, erd, eer);
    n_total++; if (er !== eer) $display("FAIL prot_err got %b want %b", er, eer); else n_pass++;
    xfer(1'b0, 32'h80, 32'h0, 4'h0, 3'b010, 4'd0, rd, er, lat);
    model(1'b0, 32'h80, 32'h0, 4'h0, 3'b010, erd, eer);
    n_total++; if (rd !== erd)  $display("FAIL prot_mem got %h want %h", rd, erd); else n_pass++;
    n_total++; if (er !== 1'b0) $display("FAIL prot_rd_err got %b want 0", er);    else n_pass++;
    idle();
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, d; logic er, eer, w; int lat; logic [3:0] s, n; logic [2:0] p;
    int unsigned r;
    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      a = 32'($urandom_range(0, DEPTH - 1)) * 4;
      if (r == 7)      a = 32'($urandom_range(256, 400));
      else if (r == 8) a = a + 32'($urandom_range(1, 3));
      w = 1'($urandom_range(0, 1));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      p = 3'($urandom_range(0, 7));
      n = 4'($urandom_range(0, 3));
      xfer(w, a, d, s, p, n, rd, er, lat);
      model(w, a, d, s, p, erd, eer);
      n_total++; if (lat !== int'(n)) $display("FAIL rnd%0d_lat got %0d want %0d", i, lat, n); else n_pass++;
      n_total++; if (er  !== eer) $display("FAIL rnd%0d_err a=%h got %b want %b", i, a, er, eer); else n_pass++;
      n_total++; if (rd  !== erd) $display("FAIL rnd%0d_rdata a=%h got %h want %h", i, a, rd, erd); else n_pass++;
      if ($urandom_range(0, 2) == 0) idle();
    end
    idle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd, erd; logic er, eer; int lat;
    xfer(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 3'b000, 4'd0, rd, er, lat);
    model(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 3'b000, erd, eer);
    xfer(1'b0, 32'h30, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, lat);
    n_total++; if (rd !== 32'hCAFEF00D) $display("FAIL pre_rst_data got %h want cafef00d", rd); else n_pass++;
    preset_n = 1'b0;
    tick();
    n_total++; if (bus.pready  !== 1'b0)  $display("FAIL mid_rst_pready got %b want 0", bus.pready);  else n_pass++;
    n_total++; if (bus.prdata  !== 32'h0) $display("FAIL mid_rst_prdata got %h want 0", bus.prdata);  else n_pass++;
    n_total++; if (bus.pslverr !== 1'b0)  $display("FAIL mid_rst_pslverr got %b want 0", bus.pslverr); else n_pass++;
    preset_n = 1'b1; bus.psel = 1'b0; bus.penable = 1'b0;
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    xfer(1'b0, 32'h30, 32'h0, 4'h0, 3'b000, 4'd0, rd, er, lat);
    n_total++; if (rd !== 32'h0) $display("FAIL post_rst_mem got %h want 0", rd); else n_pass++;
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 3'b000, 4'd1, rd, er, lat);
    n_total++; if (rd !== 32'h0) $display("FAIL post_rst_mem4 got %h want 0", rd); else n_pass++;
    idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_strobes();
    test_wait_states();
    test_errors();
    test_abort();
    test_back_to_back();
    test_prot();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
